// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I five-stage pipeline.
// Issues data-memory requests over a req/gnt/rvalid port, forms byte enables
// and lane-replicated store data, formats load data, stalls the upstream
// pipeline while an access is outstanding and aborts it after TIMEOUT cycles.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] res_i,
   input  logic [31:0] wdata_i,
   input  logic        memren_i,
   input  logic        memwen_i,
   input  logic [1:0]  wbsel_i,
   input  logic        regwen_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic [31:0] res_o,
   output logic [1:0]  wbsel_o,
   output logic [31:0] ldata_o,
   output logic        regwen_o,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_clr;
   logic             w_cnt_inc;

   logic [2:0]  w_funct3;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_both;
   logic        w_f3_ok;
   logic        w_misal;
   logic        w_bad;
   logic        w_legal;
   logic        w_timeout;
   logic [3:0]  w_store_be;
   logic [31:0] w_store_data;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_fmt;

   // Upstream slot fields go straight through to MEM/WB.
   assign pc_o    = pc_i;
   assign instr_o = instr_i;
   assign res_o   = res_i;
   assign wbsel_o = wbsel_i;

   assign w_funct3   = instr_i[14:12];
   assign w_both     = valid_i & memren_i & memwen_i;
   assign w_is_load  = valid_i & memren_i & ~memwen_i;
   assign w_is_store = valid_i & memwen_i & ~memren_i;
   assign w_misal    = ((w_funct3[1:0] == 2'b01) & res_i[0]) |
                       ((w_funct3[1:0] == 2'b10) & (|res_i[1:0]));
   assign w_bad      = w_both | ((w_is_load | w_is_store) & (~w_f3_ok | w_misal));
   assign w_legal    = (w_is_load | w_is_store) & ~w_bad;
   assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

   // Inputs are held stable while stalled, so the port fields need no registers.
   assign dmem_we_o    = memwen_i;
   assign dmem_addr_o  = {res_i[31:2], 2'b00};
   assign dmem_be_o    = memwen_i ? w_store_be : 4'b1111;
   assign dmem_wdata_o = w_store_data;

   // Legal funct3 encodings differ between loads and stores.
   always_comb begin
      w_f3_ok = 1'b0;
      if (w_is_load) begin
         case (w_funct3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_f3_ok = 1'b1;
            default:                      w_f3_ok = 1'b0;
         endcase
      end else begin
         w_f3_ok = ~w_funct3[2] & (w_funct3[1:0] != 2'b11);
      end
   end

   // Store byte enables and lane-replicated write data by access size.
   always_comb begin
      case (w_funct3[1:0])
         2'b00: begin
            w_store_be   = 4'b0001 << res_i[1:0];
            w_store_data = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            w_store_be   = res_i[1] ? 4'b1100 : 4'b0011;
            w_store_data = {2{wdata_i[15:0]}};
         end
         default: begin
            w_store_be   = 4'b1111;
            w_store_data = wdata_i;
         end
      endcase
   end

   // Lane selection and sign/zero extension of the returned read word.
   always_comb begin
      case (res_i[1:0])
         2'd0:    w_byte = dmem_rdata_i[7:0];
         2'd1:    w_byte = dmem_rdata_i[15:8];
         2'd2:    w_byte = dmem_rdata_i[23:16];
         default: w_byte = dmem_rdata_i[31:24];
      endcase
      w_half = res_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (w_funct3)
         3'd0:    w_load_fmt = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_load_fmt = {{16{w_half[15]}}, w_half};
         3'd4:    w_load_fmt = {24'd0, w_byte};
         3'd5:    w_load_fmt = {16'd0, w_half};
         default: w_load_fmt = dmem_rdata_i;
      endcase
   end

   // Access FSM outputs and next state; every non-completing cycle is a bubble.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_next     = r_state;
      w_cnt_clr  = 1'b0;
      w_cnt_inc  = 1'b0;
      dmem_req_o = 1'b0;
      stall_o    = 1'b0;
      regwen_o   = 1'b0;
      misalign_o = 1'b0;
      bus_err_o  = 1'b0;
      ldata_o    = 32'd0;
      if (rst) begin
         case (r_state)
            S_IDLE: begin
               if (w_bad) begin
                  misalign_o = 1'b1;
               end else if (w_legal) begin
                  dmem_req_o = 1'b1;
                  if (dmem_gnt_i && w_is_store) begin
                     regwen_o = regwen_i;
                  end else begin
                     stall_o   = 1'b1;
                     w_cnt_clr = 1'b1;
                     w_next    = dmem_gnt_i ? S_RESP : S_REQ;
                  end
               end else begin
                  regwen_o = regwen_i;
               end
            end
            S_REQ: begin
               dmem_req_o = 1'b1;
               if (dmem_gnt_i) begin
                  if (w_is_store) begin
                     regwen_o = regwen_i;
                     w_next   = S_IDLE;
                  end else begin
                     stall_o   = 1'b1;
                     w_cnt_clr = 1'b1;
                     w_next    = S_RESP;
                  end
               end else if (w_timeout) begin
                  bus_err_o = 1'b1;
                  w_next    = S_IDLE;
               end else begin
                  stall_o   = 1'b1;
                  w_cnt_inc = 1'b1;
               end
            end
            S_RESP: begin
               if (dmem_rvalid_i) begin
                  ldata_o  = w_load_fmt;
                  regwen_o = regwen_i;
                  w_next   = S_IDLE;
               end else if (w_timeout) begin
                  bus_err_o = 1'b1;
                  w_next    = S_IDLE;
               end else begin
                  stall_o   = 1'b1;
                  w_cnt_inc = 1'b1;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // State and timeout counter registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from pre-edge values.
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge. Expected load data is
// queued when a load is issued and compared when the stage completes it.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [31:0] pc_i, instr_i, res_i, wdata_i;
   logic        memren_i, memwen_i;
   logic [1:0]  wbsel_i;
   logic        regwen_i;
   logic [31:0] pc_o, instr_o, res_o, ldata_o;
   logic [1:0]  wbsel_o;
   logic        regwen_o, stall_o, misalign_o, bus_err_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   mem_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
      .res_i(res_i), .wdata_i(wdata_i), .memren_i(memren_i), .memwen_i(memwen_i),
      .wbsel_i(wbsel_i), .regwen_i(regwen_i), .pc_o(pc_o), .instr_o(instr_o),
      .res_o(res_o), .wbsel_o(wbsel_o), .ldata_o(ldata_o), .regwen_o(regwen_o),
      .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_load(input string tag);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         check(tag, ldata_o, exp_q.pop_front());
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic rw);
      valid_i  = 1'b1;
      memren_i = ld;
      memwen_i = st;
      instr_i  = {17'd0, f3, 5'd1, (st ? 7'h23 : 7'h03)};
      res_i    = addr;
      wdata_i  = wd;
      regwen_i = rw;
      wbsel_i  = ld ? 2'd1 : 2'd0;
   endtask

   task automatic clear_op();
      valid_i  = 1'b0;
      memren_i = 1'b0;
      memwen_i = 1'b0;
      regwen_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_stall;
      int  err_at;
      bit  done;

      rst = 1'b0;
      pc_i = 32'h0000_1004;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
      set_op(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 1'b1);
      dmem_gnt_i = 1'b1;

      // Reset: control outputs low even with a legal load presented
      mid();
      check("rst_req", dmem_req_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_regwen", regwen_o, 0);
      check("rst_misalign", misalign_o, 0);
      check("rst_bus_err", bus_err_o, 0);
      check("rst_pc_pass", pc_o, 32'h0000_1004);
      check("rst_addr_follow", dmem_addr_o, 32'h100);
      #2 rst = 1'b1;
      clear_op(); dmem_gnt_i = 1'b0;
      cyc();

      // SW with immediate grant
      set_op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 1'b0);
      dmem_gnt_i = 1'b1;
      mid();
      check("sw_req", dmem_req_o, 1);
      check("sw_we", dmem_we_o, 1);
      check("sw_addr", dmem_addr_o, 32'h100);
      check("sw_be", dmem_be_o, 4'b1111);
      check("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
      check("sw_stall", stall_o, 0);
      cyc();

      // SB at byte lane 3
      set_op(1'b0, 1'b1, 3'd0, 32'h103, 32'h0000_00A5, 1'b0);
      mid();
      check("sb_be", dmem_be_o, 4'b1000);
      check("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
      check("sb_addr", dmem_addr_o, 32'h100);
      check("sb_stall", stall_o, 0);
      cyc();

      // SH upper half
      set_op(1'b0, 1'b1, 3'd1, 32'h102, 32'h0000_1234, 1'b0);
      mid();
      check("sh_be", dmem_be_o, 4'b1100);
      check("sh_wdata", dmem_wdata_o, 32'h1234_1234);
      cyc();

      // Non-memory instruction passes regwen through
      set_op(1'b0, 1'b0, 3'd0, 32'h55, 32'd0, 1'b1);
      wbsel_i = 2'd2;
      mid();
      check("alu_regwen", regwen_o, 1);
      check("alu_req", dmem_req_o, 0);
      check("alu_ldata", ldata_o, 0);
      check("alu_wbsel", wbsel_o, 2'd2);
      check("alu_res", res_o, 32'h55);
      cyc();

      // LB best case: grant in cycle 0, rvalid in cycle 1
      set_op(1'b1, 1'b0, 3'd0, 32'h201, 32'd0, 1'b1);
      exp_q.push_back(32'hFFFF_FF80);
      dmem_gnt_i = 1'b1;
      mid();
      check("lb_c0_stall", stall_o, 1);
      check("lb_c0_regwen", regwen_o, 0);
      check("lb_c0_be", dmem_be_o, 4'b1111);
      check("lb_c0_we", dmem_we_o, 0);
      cyc();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_8000;
      mid();
      check("lb_c1_stall", stall_o, 0);
      check("lb_c1_regwen", regwen_o, 1);
      check("lb_c1_req", dmem_req_o, 0);
      check_load("lb_data");
      cyc();

      // LBU: a response arriving with the grant in IDLE is ignored
      set_op(1'b1, 1'b0, 3'd4, 32'h201, 32'd0, 1'b1);
      exp_q.push_back(32'h0000_0080);
      dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_FF00;
      mid();
      check("lbu_c0_stall", stall_o, 1);
      check("lbu_c0_regwen", regwen_o, 0);
      cyc();
      dmem_gnt_i = 1'b0; dmem_rdata_i = 32'h0000_8000;
      mid();
      check("lbu_c1_regwen", regwen_o, 1);
      check_load("lbu_data");
      cyc();
      dmem_rvalid_i = 1'b0;

      // LW misaligned: no request, one-cycle flag
      set_op(1'b1, 1'b0, 3'd2, 32'h302, 32'd0, 1'b1);
      dmem_rdata_i = 32'hFFFF_FFFF;
      mid();
      check("lw_mis_flag", misalign_o, 1);
      check("lw_mis_req", dmem_req_o, 0);
      check("lw_mis_stall", stall_o, 0);
      check("lw_mis_regwen", regwen_o, 0);
      check("lw_mis_ldata", ldata_o, 0);
      cyc();
      clear_op();
      mid();
      check("mis_clears", misalign_o, 0);
      cyc();

      // Illegal store funct3 and load+store together
      set_op(1'b0, 1'b1, 3'd4, 32'h300, 32'd0, 1'b0);
      mid();
      check("st_f3_illegal", misalign_o, 1);
      check("st_f3_noreq", dmem_req_o, 0);
      cyc();
      set_op(1'b1, 1'b1, 3'd2, 32'h300, 32'd0, 1'b1);
      mid();
      check("both_illegal", misalign_o, 1);
      check("both_regwen", regwen_o, 0);
      cyc();

      // LH upper half, grant after 3 cycles, rvalid 2 cycles after that
      set_op(1'b1, 1'b0, 3'd1, 32'h302, 32'd0, 1'b1);
      dmem_rdata_i = 32'hABCD_1234;
      exp_q.push_back(32'hFFFF_ABCD);
      n_stall = 0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         dmem_gnt_i    = (k == 3);
         dmem_rvalid_i = (k == 5);
         mid();
         if (stall_o) begin
            n_stall++;
         end else begin
            done = 1'b1;
            check("lh_done_regwen", regwen_o, 1);
            check_load("lh_data");
         end
         cyc();
      end
      check("lh_completed", done, 1);
      check("lh_stall_cycles", n_stall, 5);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;

      // SW held in REQ until grant in cycle 2
      set_op(1'b0, 1'b1, 3'd2, 32'h600, 32'h0BAD_F00D, 1'b0);
      mid();
      check("swreq_c0_stall", stall_o, 1);
      cyc();
      mid();
      check("swreq_c1_req", dmem_req_o, 1);
      check("swreq_c1_stall", stall_o, 1);
      cyc();
      dmem_gnt_i = 1'b1;
      mid();
      check("swreq_c2_req", dmem_req_o, 1);
      check("swreq_c2_stall", stall_o, 0);
      check("swreq_c2_wdata", dmem_wdata_o, 32'h0BAD_F00D);
      cyc();
      dmem_gnt_i = 1'b0;

      // LW granted, no response: bus error on the 16th RESP cycle
      set_op(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 1'b1);
      err_at = -1;
      for (int k = 0; k < 30; k++) begin
         dmem_gnt_i = (k == 0);
         mid();
         if (bus_err_o) begin
            err_at = k;
            check("to_stall", stall_o, 0);
            check("to_regwen", regwen_o, 0);
            check("to_ldata", ldata_o, 0);
            cyc();
            break;
         end
         cyc();
      end
      check("to_cycle", err_at, 16);
      clear_op();
      mid();
      check("to_idle_stall", stall_o, 0);
      check("to_err_pulse", bus_err_o, 0);
      cyc();

      // Reset in the middle of RESP abandons the load
      set_op(1'b1, 1'b0, 3'd2, 32'h500, 32'd0, 1'b1);
      dmem_gnt_i = 1'b1;
      cyc();
      dmem_gnt_i = 1'b0;
      cyc();
      mid();
      check("rstmid_resp_stall", stall_o, 1);
      #1 rst = 1'b0;
      #1;
      check("rstmid_stall", stall_o, 0);
      check("rstmid_req", dmem_req_o, 0);
      #2 rst = 1'b1;
      clear_op();
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
      mid();
      check("late_rvalid_ldata", ldata_o, 0);
      check("late_rvalid_regwen", regwen_o, 0);
      check("late_rvalid_stall", stall_o, 0);
      cyc();
      dmem_rvalid_i = 1'b0;

      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I five-stage pipeline, between the EX/MEM register and the MEM/WB register. Drives a request/grant/response data-memory port, generates byte enables and lane-replicated store data, and sign- or zero-extends load data. Stalls the upstream pipeline while an access is outstanding and emits a bubble toward MEM/WB until the access completes. Bounds every access with a response timeout.

## Interface
- TIMEOUT, 16: maximum cycles spent in REQ or RESP before the access is aborted with a bus error.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- valid_i  in  1  EX/MEM slot holds a real instruction
- pc_i, instr_i  in  32 each  PC+4 and instruction; funct3 = instr_i[14:12]
- res_i  in  32  ALU result; this is the effective address for loads and stores
- wdata_i  in  32  store data (rs2)
- memren_i, memwen_i  in  1 each  load / store
- wbsel_i  in  2  writeback select
- regwen_i  in  1  register write enable
- pc_o, instr_o, res_o, wbsel_o  out  32/32/32/2  combinational pass-through to MEM/WB
- ldata_o  out  32  formatted load data
- regwen_o  out  1  qualified register write enable
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- misalign_o  out  1  one-cycle flag: misaligned or illegal access
- bus_err_o  out  1  one-cycle flag: access timed out
- dmem_req_o, dmem_we_o  out  1 each  request; write
- dmem_addr_o  out  32  {res_i[31:2], 2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i, dmem_rvalid_i  in  1 each  request accepted; read data valid
- dmem_rdata_i  in  32  read word

## Operation
- The access is a memory op when valid_i and exactly one of memren_i or memwen_i is set. If both are set, it is illegal.
- Alignment check: halfword requires res_i[0]=0. Word requires res_i[1:0]=0.
- Legal load funct3 values: 0, 1, 2, 4, 5. Legal store funct3 values: 0, 1, 2. Any other value is illegal.
- Misaligned or illegal access:
  - No request is issued and there is no stall.
  - misalign_o=1 for that cycle; regwen_o=0; ldata_o=0.
- Stores:
  - SB: be=4'b0001<<res_i[1:0]; wdata={4{wdata_i[7:0]}}.
  - SH: be=res_i[1]?4'b1100:4'b0011; wdata={2{wdata_i[15:0]}}.
  - SW: be=4'b1111; wdata=wdata_i.
  - For a load, be=4'b1111.
- Load lane selection: byte=rdata[8*res_i[1:0]+:8], half=rdata[16*res_i[1]+:16].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
- Non-memory instruction: pass-through; ldata_o=0; regwen_o=regwen_i; no stall.
- FSM states: IDLE, REQ, RESP. Timeout counter cnt is 5 bits wide (sized so it holds TIMEOUT).
  - IDLE: a legal memory op asserts dmem_req_o combinationally.
    - Store with gnt: complete this cycle, stall_o=0, stay IDLE.
    - Load with gnt: go to RESP, stall_o=1.
    - No gnt: go to REQ, stall_o=1.
  - REQ: hold dmem_req_o and all dmem_* fields; stall_o=1 except in the completing cycle.
    - Store with gnt: complete, go to IDLE.
    - Load with gnt: go to RESP.
  - RESP: dmem_req_o=0.
    - rvalid: complete with ldata_o formatted, regwen_o=regwen_i, stall_o=0, go to IDLE.
  - In every cycle that is not a completion, regwen_o=0. This makes MEM/WB capture a bubble.
- cnt behaviour:
  - Clears on entry to REQ or RESP; increments each cycle spent in REQ or RESP.
  - At cnt==TIMEOUT-1 with no gnt/rvalid: bus_err_o=1, stall_o=0, regwen_o=0, ldata_o=0, go to IDLE.
- dmem_rvalid_i in IDLE or REQ (stray response) is ignored.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, cnt=0.
  - dmem_req_o=0, stall_o=0, regwen_o=0, misalign_o=0, bus_err_o=0.
  - Other outputs follow inputs.
- Reset asserted mid-access abandons the access; a later rvalid is ignored.
- Upstream inputs are held stable by stall_o, so dmem_* remain stable while in REQ.
- Best-case latency:
  - Store: 0 stall cycles.
  - Load: 1 stall cycle (gnt in cycle 0, rvalid in cycle 1).
- gnt and rvalid in the same cycle in IDLE: rvalid is ignored. The response is expected in RESP.

## Test plan
- SW res_i=0x100, wdata=0xDEADBEEF, gnt held high -> req=1, we=1, addr=0x100, be=4'b1111, stall_o=0 in the same cycle.
- SB res_i=0x103, wdata=0x000000A5 -> be=4'b1000, dmem_wdata=0xA5A5A5A5. SH res_i=0x102 -> be=4'b1100.
- LB res_i=0x201, rdata=0x00008000 with gnt at cycle 0 and rvalid at cycle 1:
  - Cycle 0: stall_o=1, regwen_o=0.
  - Cycle 1: ldata_o=0xFFFFFF80, regwen_o=1, stall_o=0.
  - LBU with the same data gives ldata_o=0x00000080.
- LW res_i=0x302 -> no request; misalign_o=1 for one cycle; regwen_o=0; stall_o=0.
- Load with gnt delayed 3 cycles, then rvalid after 2 more -> stall_o high for exactly 5 cycles, then one completion cycle with the correct data.
- Load granted, rvalid never arrives, TIMEOUT=16 -> bus_err_o pulses at the 16th RESP cycle and the FSM returns to IDLE. Repeat with rst pulsed mid-RESP: the FSM returns to IDLE and a late rvalid has no effect.
